// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward selects, FSM states
// and the saturating performance-counter increment.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RD  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_ALU = 2'b10
    } fwd_e;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        ERR     = 2'b10
    } state_e;

    localparam int unsigned PERF_W = 16;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] val,
                                                   input logic              en);
        if (en && (val != '1)) begin
            return val + PERF_W'(1);
        end
        return val;
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Single-operand forwarding compare: memory stage wins over writeback, and
// register 0 is never forwarded.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rdm,
    input  logic [WIDTH-1:0] rdw,
    input  logic             regwritem,
    input  logic             regwritew,
    output fwd_e             fwd
);

    always_comb begin
        fwd = FWD_RD;
        if (rs != '0) begin
            if (regwritem && (rdm == rs)) begin
                fwd = FWD_ALU;
            end else if (regwritew && (rdw == rs)) begin
                fwd = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use/branch/memory-wait
// stalls and flushes, memory-timeout error and stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Rs1D,
    input  logic [WIDTH-1:0] Rs2D,
    input  logic [WIDTH-1:0] Rs1E,
    input  logic [WIDTH-1:0] Rs2E,
    input  logic [WIDTH-1:0] RdE,
    input  logic [WIDTH-1:0] RdM,
    input  logic [WIDTH-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic             PerfClr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [15:0]      StallCycles,
    output logic [15:0]      FlushCount
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    state_e                state_q, state_d;
    logic [WaitW-1:0]      wait_q, wait_d;
    logic [PERF_W-1:0]     stall_cnt_q, flush_cnt_q;
    fwd_e                  fwd_a, fwd_b;
    logic                  mem_stall, load_use, any_stall, any_flush;

    fwd_sel #(.WIDTH(WIDTH)) u_fwd_a (
        .rs        (Rs1E),
        .rdm       (RdM),
        .rdw       (RdW),
        .regwritem (RegWriteM),
        .regwritew (RegWriteW),
        .fwd       (fwd_a)
    );

    fwd_sel #(.WIDTH(WIDTH)) u_fwd_b (
        .rs        (Rs2E),
        .rdm       (RdM),
        .rdw       (RdW),
        .regwritem (RegWriteM),
        .regwritew (RegWriteW),
        .fwd       (fwd_b)
    );

    // Reset masks the selects so 11 can never escape, even while rst is held.
    assign ForwardAE = rst ? 2'b00 : fwd_a;
    assign ForwardBE = rst ? 2'b00 : fwd_b;

    assign mem_stall = (state_q != ERR) && MemReqM && !MemReadyM;
    assign load_use  = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            RUN: begin
                wait_d = '0;
                if (mem_stall) state_d = MEMWAIT;
            end
            MEMWAIT: begin
                wait_d = wait_q + WaitW'(1);
                if (MemReadyM) begin
                    state_d = RUN;
                end else if (wait_d == WaitW'(MEM_TIMEOUT)) begin
                    state_d = ERR;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // A branch seen during a memory stall stays in E (StallE) and flushes once it clears.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!rst) begin
            if (mem_stall || (state_q == ERR)) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign MemErr    = (state_q == ERR);
    assign any_stall = StallF | StallD | StallE | StallM;
    assign any_flush = FlushD | FlushE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (PerfClr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= sat_inc(stall_cnt_q, any_stall);
            flush_cnt_q <= sat_inc(flush_cnt_q, any_flush);
        end
    end

    assign StallCycles = stall_cnt_q;
    assign FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of combinational vectors in RUN plus
// hand-written multi-cycle sequences for memory wait, timeout, reset and counters.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM, PerfClr;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [15:0] StallCycles, FlushCount;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.WIDTH(5), .MEM_TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .LoadE       (LoadE),
        .PCSrcE      (PCSrcE),
        .MemReqM     (MemReqM),
        .MemReadyM   (MemReadyM),
        .PerfClr     (PerfClr),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushW      (FlushW),
        .MemErr      (MemErr),
        .StallCycles (StallCycles),
        .FlushCount  (FlushCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww, loade, pcsrce;
        logic [1:0] fa, fb;
        logic [6:0] ctl;  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    } vec_t;

    localparam logic [6:0] CtlNone = 7'b0000000;
    localparam logic [6:0] CtlLoad = 7'b1100010;
    localparam logic [6:0] CtlBr   = 7'b0000110;
    localparam logic [6:0] CtlMem  = 7'b1111001;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                                input logic rwm, rww, loade, pcsrce,
                                input logic [1:0] fa, fb, input logic [6:0] ctl);
        vec_t v;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde;
        v.rdm = rdm; v.rdw = rdw; v.rwm = rwm; v.rww = rww; v.loade = loade;
        v.pcsrce = pcsrce; v.fa = fa; v.fb = fb; v.ctl = ctl;
        return v;
    endfunction

    function automatic logic [6:0] ctl_now();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0; PCSrcE = 1'b0;
        MemReqM = 1'b0; MemReadyM = 1'b0; PerfClr = 1'b0;
    endtask

    task automatic clear_perf();
        @(negedge clk);
        PerfClr = 1'b1;
        @(negedge clk);
        PerfClr = 1'b0;
    endtask

    initial begin
        // Reset asserted with every hazard source active: all outputs must be quiet.
        idle();
        rst = 1'b1;
        Rs1E = 5'd5; Rs2E = 5'd5; RdM = 5'd5; RdW = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
        LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1; MemReqM = 1'b1;
        #2;
        chk("rst_ctl", 32'(ctl_now()), 32'(CtlNone));
        chk("rst_fwd", 32'({ForwardAE, ForwardBE}), 32'd0);
        chk("rst_memerr", 32'(MemErr), 32'd0);
        chk("rst_stallcnt", 32'(StallCycles), 32'd0);
        chk("rst_flushcnt", 32'(FlushCount), 32'd0);
        @(negedge clk);
        idle();
        rst = 1'b0;

        vecs[0]  = mk(0, 0, 5, 3, 0, 5, 5, 1, 1, 0, 0, 2'b10, 2'b00, CtlNone);
        vecs[1]  = mk(0, 0, 0, 3, 0, 5, 5, 1, 1, 0, 0, 2'b00, 2'b00, CtlNone);
        vecs[2]  = mk(0, 0, 5, 6, 0, 5, 6, 1, 1, 0, 0, 2'b10, 2'b01, CtlNone);
        vecs[3]  = mk(0, 0, 5, 5, 0, 5, 5, 0, 1, 0, 0, 2'b01, 2'b01, CtlNone);
        vecs[4]  = mk(0, 0, 5, 5, 0, 5, 5, 0, 0, 0, 0, 2'b00, 2'b00, CtlNone);
        vecs[5]  = mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, CtlLoad);
        vecs[6]  = mk(9, 0, 0, 0, 9, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, CtlLoad);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, CtlNone);
        vecs[8]  = mk(3, 4, 0, 0, 7, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, CtlNone);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, CtlBr);
        vecs[10] = mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, CtlBr);
        vecs[11] = mk(0, 0, 31, 31, 0, 31, 31, 1, 1, 0, 0, 2'b10, 2'b10, CtlNone);
        vecs[12] = mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, CtlNone);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e;
            Rs2E = vecs[i].rs2e; RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
            RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            LoadE = vecs[i].loade; PCSrcE = vecs[i].pcsrce;
            #1;
            chk($sformatf("vec%0d_fa", i), 32'(ForwardAE), 32'(vecs[i].fa));
            chk($sformatf("vec%0d_fb", i), 32'(ForwardBE), 32'(vecs[i].fb));
            chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
        end

        // One load-use cycle: one stall cycle and one flush cycle counted.
        @(negedge clk);
        idle();
        clear_perf();
        LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        chk("lu_ctl", 32'(ctl_now()), 32'(CtlLoad));
        @(negedge clk);
        idle();
        #1;
        chk("lu_ctl_after", 32'(ctl_now()), 32'(CtlNone));
        chk("lu_stallcnt", 32'(StallCycles), 32'd1);
        chk("lu_flushcnt", 32'(FlushCount), 32'd1);

        // Branch with load-use, counted once.
        clear_perf();
        LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
        @(negedge clk);
        idle();
        #1;
        chk("br_flushcnt", 32'(FlushCount), 32'd1);
        chk("br_stallcnt", 32'(StallCycles), 32'd0);

        // Three-cycle memory wait, released on the fourth cycle.
        clear_perf();
        for (int i = 0; i < 3; i++) begin
            MemReqM = 1'b1; MemReadyM = 1'b0;
            #1;
            chk($sformatf("mw_ctl%0d", i), 32'(ctl_now()), 32'(CtlMem));
            @(negedge clk);
        end
        MemReadyM = 1'b1;
        #1;
        chk("mw_ready_ctl", 32'(ctl_now()), 32'(CtlNone));
        @(negedge clk);
        idle();
        #1;
        chk("mw_run_ctl", 32'(ctl_now()), 32'(CtlNone));
        chk("mw_stallcnt", 32'(StallCycles), 32'd3);
        chk("mw_memerr", 32'(MemErr), 32'd0);

        // Branch taken during a memory stall is flushed only once the stall clears.
        clear_perf();
        PCSrcE = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0;
        #1;
        chk("brmw_hold_ctl", 32'(ctl_now()), 32'(CtlMem));
        @(negedge clk);
        MemReadyM = 1'b1;
        #1;
        chk("brmw_flush_ctl", 32'(ctl_now()), 32'(CtlBr));
        @(negedge clk);
        idle();
        #1;
        chk("brmw_flushcnt", 32'(FlushCount), 32'd1);

        // Timeout: no error after 15 unready cycles, error after 16, then sticky.
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 15; i++) @(negedge clk);
        #1;
        chk("to_memerr_15", 32'(MemErr), 32'd0);
        @(negedge clk);
        #1;
        chk("to_memerr_16", 32'(MemErr), 32'd1);
        @(negedge clk);
        MemReqM = 1'b0; MemReadyM = 1'b1; PCSrcE = 1'b1;
        @(negedge clk);
        #1;
        chk("to_sticky", 32'(MemErr), 32'd1);
        chk("to_err_ctl", 32'(ctl_now()), 32'(CtlMem));
        idle();

        // Stall counter saturates while parked in ERR, then clears on PerfClr.
        clear_perf();
        for (int i = 0; i < 65540; i++) @(negedge clk);
        #1;
        chk("sat_stallcnt", 32'(StallCycles), 32'hFFFF);
        @(negedge clk);
        PerfClr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_stallcnt", 32'(StallCycles), 32'd0);
        chk("clr_flushcnt", 32'(FlushCount), 32'd0);
        @(negedge clk);
        PerfClr = 1'b0;

        // Asynchronous reset out of ERR.
        #2;
        rst = 1'b1;
        Rs1E = 5'd3; RdM = 5'd3; RegWriteM = 1'b1;
        #1;
        chk("rerr_memerr", 32'(MemErr), 32'd0);
        chk("rerr_ctl", 32'(ctl_now()), 32'(CtlNone));
        chk("rerr_fwd", 32'(ForwardAE), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        chk("rerr_run_ctl", 32'(ctl_now()), 32'(CtlNone));
        chk("rerr_run_memerr", 32'(MemErr), 32'd0);

        // Reset out of MEMWAIT leaves no residual stall.
        MemReqM = 1'b1; MemReadyM = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        chk("rmw_ctl", 32'(ctl_now()), 32'(CtlNone));
        @(negedge clk);
        #1;
        chk("rmw_ctl2", 32'(ctl_now()), 32'(CtlNone));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
